// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Holds the fetch state encoding, the NOP word bit and a saturating counter helper.
package imem_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    localparam int FETCH_CNT_W = 16;

    // A NOP is the all-zero instruction word; replicate this bit to any word width.
    localparam logic NOP_BIT = 1'b0;

    function automatic logic [FETCH_CNT_W-1:0] sat_inc(input logic [FETCH_CNT_W-1:0] v);
        logic [FETCH_CNT_W-1:0] r;
        r = (v == {FETCH_CNT_W{1'b1}}) ? v : v + {{(FETCH_CNT_W-1){1'b0}}, 1'b1};
        return r;
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Sequential instruction fetch controller in front of a 1-cycle-latency instruction memory.
// Supports start/restart, stall (re-present), redirect (flush + new stream) and a terminal address.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int START_ADDR = 0,
    parameter int LAST_ADDR  = 37
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_target,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [DATA_WIDTH-1:0]  imem_data,
    output logic [DATA_WIDTH-1:0]  instr_out,
    output logic                   instr_valid,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   done,
    output logic [15:0]            fetch_count
);

    localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

    fetch_state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]        pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]        issued_pc_q, issued_pc_d;
    logic                         issued_valid_q, issued_valid_d;
    logic [FETCH_CNT_W-1:0]       fetch_count_q, fetch_count_d;

    logic [ADDR_WIDTH-1:0]        issue_addr;
    logic                         issue_en;
    logic                         present_valid;
    logic                         last_delivering;

    // A redirect squashes whatever is on the output this cycle.
    assign present_valid   = issued_valid_q & ~redirect;
    assign last_delivering = issued_valid_q && (issued_pc_q == LAST_A);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pc_q           <= START_A;
            issued_pc_q    <= '0;
            issued_valid_q <= 1'b0;
            fetch_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            issued_pc_q    <= issued_pc_d;
            issued_valid_q <= issued_valid_d;
            fetch_count_q  <= fetch_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!redirect && !stall && last_delivering) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue, PC and counter logic
    always_comb begin
        issue_addr    = '0;
        issue_en      = 1'b0;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // After the final delivery the address bus parks on the last issued address.
                if (state_q == ST_DONE) begin
                    issue_addr = issued_pc_q;
                end
                if (start) begin
                    issue_addr    = START_A;
                    issue_en      = 1'b1;
                    pc_d          = START_A + ONE_A;
                    fetch_count_d = '0;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    issue_addr = redirect_target;
                    issue_en   = 1'b1;
                    pc_d       = redirect_target + ONE_A;
                end else if (stall) begin
                    issue_addr = issued_pc_q;
                    issue_en   = issued_valid_q;
                end else if (last_delivering) begin
                    issue_addr = issued_pc_q;
                    issue_en   = 1'b0;
                end else begin
                    issue_addr = pc_q;
                    issue_en   = 1'b1;
                    pc_d       = pc_q + ONE_A;
                end
                if (present_valid && !stall) begin
                    fetch_count_d = sat_inc(fetch_count_q);
                end
            end
            default: begin
                issue_addr = '0;
                issue_en   = 1'b0;
            end
        endcase
        issued_pc_d    = issue_addr;
        issued_valid_d = issue_en;
    end

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        imem_addr   = rst_n ? issue_addr : '0;
        instr_valid = rst_n & present_valid;
        instr_pc    = rst_n ? issued_pc_q : '0;
        instr_out   = (rst_n && present_valid) ? imem_data : {DATA_WIDTH{NOP_BIT}};
        done        = (state_q == ST_DONE);
        fetch_count = fetch_count_q;
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed, table-driven bench for imem_fetch_ctrl with a registered-read memory model.
// A second instance with LAST_ADDR=5 covers address wrap at the top of the space.
module tb_imem_fetch_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n, start, stall, redirect;
    logic [AW-1:0] redirect_target;

    logic [AW-1:0] imem_addr, instr_pc, u2_imem_addr, u2_instr_pc;
    logic [DW-1:0] imem_data, instr_out, u2_imem_data, u2_instr_out;
    logic          instr_valid, done, u2_instr_valid, u2_done;
    logic [15:0]   fetch_count, u2_fetch_count;

    logic [DW-1:0] mem [0:1023];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(0), .LAST_ADDR(37)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr_out(instr_out), .instr_valid(instr_valid), .instr_pc(instr_pc),
        .done(done), .fetch_count(fetch_count)
    );

    imem_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(0), .LAST_ADDR(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_addr(u2_imem_addr), .imem_data(u2_imem_data),
        .instr_out(u2_instr_out), .instr_valid(u2_instr_valid), .instr_pc(u2_instr_pc),
        .done(u2_done), .fetch_count(u2_fetch_count)
    );

    function automatic logic [31:0] word_at(input int a);
        logic [31:0] w;
        if (a == 3) w = 32'h4801_5500;
        else        w = {16'hC0DE, 16'(a)};
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = word_at(i);
    end

    always @(posedge clk) begin
        imem_data    <= mem[imem_addr];
        u2_imem_data <= mem[u2_imem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic s, input logic st, input logic rd,
                          input logic [AW-1:0] t);
        rst_n = r; start = s; stall = st; redirect = rd; redirect_target = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          rst_n, start, stall, redirect;
        logic [AW-1:0] tgt;
        logic [AW-1:0] e_addr;
        logic          e_valid;
        logic [AW-1:0] e_pc;
        logic          e_done;
        logic [15:0]   e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic st, input logic rd,
                                input int t, input int ea, input logic ev, input int ep,
                                input logic ed, input int ec);
        vec_t v;
        v.rst_n = r; v.start = s; v.stall = st; v.redirect = rd; v.tgt = AW'(t);
        v.e_addr = AW'(ea); v.e_valid = ev; v.e_pc = AW'(ep); v.e_done = ed; v.e_cnt = 16'(ec);
        return v;
    endfunction

    // Walk the stream from first_pc through address 37, then confirm the halt.
    task automatic run_to_last(input int first_pc, input int cnt0, input string tag);
        int p;
        p = first_pc;
        for (int i = 0; i < 100 && p <= 37; i++) begin
            set_in(1, 0, 0, 0, '0);
            #1;
            chk({tag, "_pc"},    32'(instr_pc), 32'(p));
            chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
            chk({tag, "_data"},  instr_out, word_at(p));
            chk({tag, "_cnt"},   32'(fetch_count), 32'(cnt0 + p - first_pc));
            chk({tag, "_addr"},  32'(imem_addr), (p == 37) ? 32'd37 : 32'(p + 1));
            tick();
            p++;
        end
        #1;
        chk({tag, "_done"},      32'(done), 32'd1);
        chk({tag, "_done_vld"},  32'(instr_valid), 32'd0);
        chk({tag, "_done_cnt"},  32'(fetch_count), 32'(cnt0 + 38 - first_pc));
        chk({tag, "_done_addr"}, 32'(imem_addr), 32'd37);
        tick();
        #1;
        chk({tag, "_park_addr"}, 32'(imem_addr), 32'd37);
        chk({tag, "_park_done"}, 32'(done), 32'd1);
    endtask

    vec_t vt [19];

    initial begin
        set_in(0, 0, 0, 0, '0);
        repeat (2) @(posedge clk);
        #1;

        //            rst st  stl rd  tgt  addr vld pc  done cnt
        vt[0]  = mk(0,  0,  0,  0,  0,   0,   0,  0,  0,   0);
        vt[1]  = mk(1,  0,  0,  0,  0,   0,   0,  0,  0,   0);
        vt[2]  = mk(1,  1,  0,  0,  0,   0,   0,  0,  0,   0);
        vt[3]  = mk(1,  0,  0,  0,  0,   1,   1,  0,  0,   0);
        vt[4]  = mk(1,  0,  0,  0,  0,   2,   1,  1,  0,   1);
        vt[5]  = mk(1,  0,  0,  0,  0,   3,   1,  2,  0,   2);
        vt[6]  = mk(1,  0,  0,  0,  0,   4,   1,  3,  0,   3);
        vt[7]  = mk(1,  0,  0,  0,  0,   5,   1,  4,  0,   4);
        vt[8]  = mk(1,  0,  1,  0,  0,   5,   1,  5,  0,   5);
        vt[9]  = mk(1,  0,  1,  0,  0,   5,   1,  5,  0,   5);
        vt[10] = mk(1,  0,  0,  0,  0,   6,   1,  5,  0,   5);
        vt[11] = mk(1,  0,  0,  0,  0,   7,   1,  6,  0,   6);
        vt[12] = mk(1,  0,  0,  0,  0,   8,   1,  7,  0,   7);
        vt[13] = mk(1,  0,  0,  1,  12,  12,  0,  8,  0,   8);
        vt[14] = mk(1,  0,  0,  0,  0,   13,  1,  12, 0,   8);
        vt[15] = mk(1,  1,  0,  0,  0,   14,  1,  13, 0,   9);
        vt[16] = mk(1,  0,  0,  0,  0,   15,  1,  14, 0,   10);
        vt[17] = mk(1,  0,  1,  1,  20,  20,  0,  15, 0,   11);
        vt[18] = mk(1,  0,  0,  0,  0,   21,  1,  20, 0,   11);

        for (int i = 0; i < 19; i++) begin
            set_in(vt[i].rst_n, vt[i].start, vt[i].stall, vt[i].redirect, vt[i].tgt);
            #1;
            chk($sformatf("vec%0d_addr", i),  32'(imem_addr),   32'(vt[i].e_addr));
            chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d_pc", i),    32'(instr_pc),    32'(vt[i].e_pc));
            chk($sformatf("vec%0d_done", i),  32'(done),        32'(vt[i].e_done));
            chk($sformatf("vec%0d_cnt", i),   32'(fetch_count), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d_data", i),  instr_out,
                vt[i].e_valid ? word_at(int'(vt[i].e_pc)) : 32'd0);
            tick();
        end

        // Remainder of the disturbed stream: 8 + 3 delivered before pc 20 is counted.
        run_to_last(21, 12, "run1");

        // Restart from DONE and run a clean stream 0..37.
        set_in(1, 1, 0, 0, '0);
        #1;
        chk("restart_addr", 32'(imem_addr), 32'd0);
        chk("restart_done", 32'(done), 32'd1);
        tick();
        run_to_last(0, 0, "run2");

        // Wrap at the top of the address space on the LAST_ADDR=5 instance.
        set_in(0, 0, 0, 0, '0);
        tick();
        set_in(1, 1, 0, 0, '0);
        tick();
        set_in(1, 0, 0, 1, 10'd1023);
        #1;
        chk("wrap_flush_vld",  32'(u2_instr_valid), 32'd0);
        chk("wrap_flush_addr", 32'(u2_imem_addr), 32'd1023);
        chk("wrap_flush_data", u2_instr_out, 32'd0);
        tick();
        set_in(1, 0, 0, 0, '0);
        #1;
        chk("wrap_top_pc",   32'(u2_instr_pc), 32'd1023);
        chk("wrap_top_vld",  32'(u2_instr_valid), 32'd1);
        chk("wrap_top_addr", 32'(u2_imem_addr), 32'd0);
        chk("wrap_top_data", u2_instr_out, word_at(1023));
        tick();
        for (int p = 0; p <= 5; p++) begin
            #1;
            chk($sformatf("wrap_pc%0d", p),  32'(u2_instr_pc), 32'(p));
            chk($sformatf("wrap_vld%0d", p), 32'(u2_instr_valid), 32'd1);
            tick();
        end
        #1;
        chk("wrap_done",     32'(u2_done), 32'd1);
        chk("wrap_done_cnt", 32'(u2_fetch_count), 32'd7);
        chk("wrap_done_vld", 32'(u2_instr_valid), 32'd0);

        // Reset in the middle of a running stream with stall and redirect both asserted.
        chk("pre_rst_run", 32'(instr_valid), 32'd1);
        set_in(0, 0, 1, 1, 10'd300);
        #1;
        chk("in_rst_addr", 32'(imem_addr), 32'd0);
        chk("in_rst_vld",  32'(instr_valid), 32'd0);
        chk("in_rst_pc",   32'(instr_pc), 32'd0);
        chk("in_rst_data", instr_out, 32'd0);
        tick();
        set_in(1, 0, 0, 0, '0);
        #1;
        chk("post_rst_addr", 32'(imem_addr), 32'd0);
        chk("post_rst_vld",  32'(instr_valid), 32'd0);
        chk("post_rst_pc",   32'(instr_pc), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_cnt",  32'(fetch_count), 32'd0);
        tick();
        #1;
        chk("idle_hold_addr", 32'(imem_addr), 32'd0);
        chk("idle_hold_vld",  32'(instr_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
